// File: rtl/mfm_write_encoder_pkg.sv
// Shared types for the MFM write path: controller states, precompensation
// classes and the cell-pattern classifier used at each cell boundary.
package mfm_write_encoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PC_NOMINAL = 2'd0,
    PC_EARLY   = 2'd1,
    PC_LATE    = 2'd2
  } precomp_t;

  // Data bit whose clock cell is suppressed to form the A1 sync mark.
  localparam int MARK_BIT = 2;

  // Window is w[-2..+2] packed as bits [4:0].
  // A pulse with a close neighbour behind it is shifted early.
  // A pulse with a close neighbour ahead of it is shifted late.
  function automatic precomp_t classify_window(input logic [4:0] w);
    precomp_t pc;
    pc = PC_NOMINAL;
    if (w == 5'b10100) begin
      pc = PC_EARLY;
    end else if (w == 5'b00101) begin
      pc = PC_LATE;
    end
    return pc;
  endfunction

endpackage

// File: rtl/mfm_encode_byte.sv
// Combinational MFM encoder: one byte plus the previous data bit becomes
// sixteen cells, MSB first, as clock/data pairs.
module mfm_encode_byte
  import mfm_write_encoder_pkg::*;
(
  input  logic [7:0]  data,
  input  logic        prev_bit,
  input  logic        mark,
  output logic [15:0] cells,
  output logic        next_prev
);

  logic [8:0] bit_chain;

  assign bit_chain = {prev_bit, data};
  assign next_prev = data[0];

  always_comb begin
    cells = '0;
    for (int i = 0; i < 8; i++) begin
      cells[2*i+1] = ~(bit_chain[i+1] | bit_chain[i]);
      cells[2*i]   = bit_chain[i];
    end
    if (mark) begin
      cells[2*MARK_BIT+1] = 1'b0;
    end
  end

endmodule

// File: rtl/mfm_write_encoder.sv
// MFM write encoder: byte handshake, holding register, 5-cell lookahead
// window with write precompensation, and fixed-width flux pulses.
module mfm_write_encoder
  import mfm_write_encoder_pkg::*;
#(
  parameter logic [7:0] CELL_CLOCKS = 8'd16,
  parameter logic [7:0] PULSE_WIDTH = 8'd4
) (
  input  logic       MASTER_CLK,
  input  logic       RESET,
  input  logic       CLKEN,
  input  logic [7:0] WR_DATA,
  input  logic       WR_MARK,
  input  logic       WR_LAST,
  input  logic       WR_VALID,
  output logic       WR_READY,
  input  logic [3:0] PRECOMP,
  output logic       FD_WRDATA,
  output logic       FD_WRGATE,
  output logic       BUSY,
  output logic       UNDERRUN
);

  localparam logic [7:0] HALF_CELL  = CELL_CLOCKS >> 1;
  localparam logic [7:0] MAX_SHIFT  = HALF_CELL - 8'd1;
  localparam logic [7:0] LAST_COUNT = CELL_CLOCKS - 8'd1;

  state_t      state, state_next;
  logic [7:0]  cell_cnt;
  logic        boundary, accept;
  logic        hold_valid, hold_mark, hold_last;
  logic [7:0]  hold_data;
  logic [15:0] enc_word;
  logic [3:0]  cells_left;
  logic        word_last, prev_bit;
  logic [4:0]  win, win_next;
  logic        flush_done;
  logic        pulse_due, launch;
  logic [7:0]  pulse_at, pulse_left;
  logic [7:0]  precomp_clamped, pulse_start_next;
  logic        load_word, shift_en, shift_bit, set_underrun;
  logic [7:0]  enc_data;
  logic        enc_mark, enc_prev, enc_next_prev;
  logic [15:0] enc_cells;

  assign accept   = WR_VALID && WR_READY;
  assign WR_READY = (state == ST_IDLE) || (state == ST_RUN && !hold_valid && !word_last);
  assign BUSY     = (state != ST_IDLE);
  assign boundary = CLKEN && (state != ST_IDLE) && (cell_cnt == LAST_COUNT);

  // The first byte of a write bypasses the holding register and starts from p = 0.
  assign enc_data = (state == ST_IDLE) ? WR_DATA : hold_data;
  assign enc_mark = (state == ST_IDLE) ? WR_MARK : hold_mark;
  assign enc_prev = (state == ST_IDLE) ? 1'b0 : prev_bit;

  mfm_encode_byte u_encode (
    .data      (enc_data),
    .prev_bit  (enc_prev),
    .mark      (enc_mark),
    .cells     (enc_cells),
    .next_prev (enc_next_prev)
  );

  always_ff @(posedge MASTER_CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    load_word    = 1'b0;
    shift_en     = 1'b0;
    shift_bit    = 1'b0;
    set_underrun = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          load_word  = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (boundary) begin
          if (cells_left != 4'd0) begin
            shift_en  = 1'b1;
            shift_bit = enc_word[15];
          end else if (hold_valid) begin
            load_word = 1'b1;
          end else begin
            shift_en     = 1'b1;
            set_underrun = !word_last;
            state_next   = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (boundary) begin
          if (!flush_done) begin
            shift_en = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    win_next = win;
    if (load_word) begin
      win_next = {(state == ST_IDLE) ? 4'b0000 : win[3:0], enc_cells[15]};
    end else if (shift_en) begin
      win_next = {win[3:0], shift_bit};
    end
  end

  always_comb begin
    precomp_clamped = ({4'd0, PRECOMP} > MAX_SHIFT) ? MAX_SHIFT : {4'd0, PRECOMP};
    case (classify_window(win_next))
      PC_EARLY: pulse_start_next = HALF_CELL - precomp_clamped;
      PC_LATE:  pulse_start_next = HALF_CELL + precomp_clamped;
      default:  pulse_start_next = HALF_CELL;
    endcase
  end

  // Start offsets never reach 0, so a pulse launches on the count just before it.
  assign launch = CLKEN && pulse_due && (state != ST_IDLE) && (cell_cnt + 8'd1 == pulse_at);

  always_ff @(posedge MASTER_CLK) begin
    if (RESET) begin
      cell_cnt   <= '0;
      win        <= '0;
      pulse_due  <= 1'b0;
      pulse_at   <= '0;
      flush_done <= 1'b0;
    end else begin
      if (state == ST_IDLE || state_next == ST_IDLE) begin
        cell_cnt <= '0;
      end else if (CLKEN) begin
        cell_cnt <= (cell_cnt == LAST_COUNT) ? 8'd0 : cell_cnt + 8'd1;
      end
      if (load_word || shift_en) begin
        win       <= win_next;
        pulse_due <= win_next[2];
        pulse_at  <= pulse_start_next;
      end
      if (state == ST_FLUSH && state_next == ST_IDLE) begin
        pulse_due <= 1'b0;
      end
      flush_done <= (state == ST_FLUSH) && (flush_done || boundary);
    end
  end

  always_ff @(posedge MASTER_CLK) begin
    if (RESET) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_mark  <= 1'b0;
      hold_last  <= 1'b0;
      enc_word   <= '0;
      cells_left <= '0;
      word_last  <= 1'b0;
      prev_bit   <= 1'b0;
    end else begin
      if (load_word) begin
        enc_word   <= {enc_cells[14:0], 1'b0};
        cells_left <= 4'd15;
        word_last  <= (state == ST_IDLE) ? WR_LAST : hold_last;
        prev_bit   <= enc_next_prev;
      end else if (shift_en && state == ST_RUN && cells_left != 4'd0) begin
        enc_word   <= {enc_word[14:0], 1'b0};
        cells_left <= cells_left - 4'd1;
      end
      if ((load_word && state == ST_RUN) || (state == ST_FLUSH && state_next == ST_IDLE)) begin
        hold_valid <= 1'b0;
      end
      if (accept && state == ST_RUN) begin
        hold_valid <= 1'b1;
        hold_data  <= WR_DATA;
        hold_mark  <= WR_MARK;
        hold_last  <= WR_LAST;
      end
    end
  end

  // A pulse runs to completion on enabled clocks even after the gate drops.
  always_ff @(posedge MASTER_CLK) begin
    if (RESET) begin
      FD_WRDATA  <= 1'b0;
      pulse_left <= '0;
      FD_WRGATE  <= 1'b0;
      UNDERRUN   <= 1'b0;
    end else begin
      FD_WRGATE <= (state_next != ST_IDLE);
      if (set_underrun) begin
        UNDERRUN <= 1'b1;
      end else if (accept && state == ST_IDLE) begin
        UNDERRUN <= 1'b0;
      end
      if (CLKEN) begin
        if (launch) begin
          FD_WRDATA  <= 1'b1;
          pulse_left <= PULSE_WIDTH - 8'd1;
        end else if (FD_WRDATA) begin
          if (pulse_left == 8'd0) begin
            FD_WRDATA <= 1'b0;
          end else begin
            pulse_left <= pulse_left - 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mfm_write_encoder.sv
// Directed bench for mfm_write_encoder: cell streams are rebuilt from pulse
// positions relative to the gate rise and compared with hand-encoded words.
module tb_mfm_write_encoder;

  logic       MASTER_CLK = 1'b0;
  logic       RESET;
  logic       CLKEN;
  logic [7:0] WR_DATA;
  logic       WR_MARK;
  logic       WR_LAST;
  logic       WR_VALID;
  logic       WR_READY;
  logic [3:0] PRECOMP;
  logic       FD_WRDATA;
  logic       FD_WRGATE;
  logic       BUSY;
  logic       UNDERRUN;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic clken_half = 1'b0;
  logic clken_toggle = 1'b0;

  int rise_q[$];
  int width_q[$];
  int t0 = 0;
  int rise_abs = 0;
  int gate_dur = 0;
  logic gate_q = 1'b0;
  logic wd_q = 1'b0;

  mfm_write_encoder dut (
    .MASTER_CLK (MASTER_CLK),
    .RESET      (RESET),
    .CLKEN      (CLKEN),
    .WR_DATA    (WR_DATA),
    .WR_MARK    (WR_MARK),
    .WR_LAST    (WR_LAST),
    .WR_VALID   (WR_VALID),
    .WR_READY   (WR_READY),
    .PRECOMP    (PRECOMP),
    .FD_WRDATA  (FD_WRDATA),
    .FD_WRGATE  (FD_WRGATE),
    .BUSY       (BUSY),
    .UNDERRUN   (UNDERRUN)
  );

  always #5 MASTER_CLK = ~MASTER_CLK;

  always @(posedge MASTER_CLK) begin
    cyc <= cyc + 1;
    clken_toggle <= ~clken_toggle;
  end

  assign CLKEN = clken_half ? clken_toggle : 1'b1;

  // Pulse and gate timeline, as offsets from the cycle the gate rose.
  always @(negedge MASTER_CLK) begin
    if (FD_WRGATE && !gate_q) begin
      t0 = cyc;
      rise_q.delete();
      width_q.delete();
    end
    if (!FD_WRGATE && gate_q) gate_dur = cyc - t0;
    if (FD_WRDATA && !wd_q) begin
      rise_q.push_back(cyc - t0);
      rise_abs = cyc;
    end
    if (!FD_WRDATA && wd_q) width_q.push_back(cyc - rise_abs);
    gate_q = FD_WRGATE;
    wd_q = FD_WRDATA;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic mark, input logic last,
                               input bit keep_valid, output int acc_cyc);
    int n;
    WR_DATA = data;
    WR_MARK = mark;
    WR_LAST = last;
    WR_VALID = 1'b1;
    n = 0;
    while (!WR_READY && n < 2000) begin
      @(negedge MASTER_CLK);
      n++;
    end
    acc_cyc = cyc;
    checkOutput("handshake_ready", {31'd0, WR_READY}, 32'd1);
    @(posedge MASTER_CLK);
    @(negedge MASTER_CLK);
    if (!keep_valid) WR_VALID = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (FD_WRGATE && n < 5000) begin
      @(negedge MASTER_CLK);
      n++;
    end
    checkOutput({tag, "_gate_drop"}, {31'd0, FD_WRGATE}, 32'd0);
    repeat (2) @(negedge MASTER_CLK);
    #1;
  endtask

  function automatic int riseAt(input int i);
    if (i < rise_q.size()) return rise_q[i];
    return -1;
  endfunction

  function automatic int widthAt(input int i);
    if (i < width_q.size()) return width_q[i];
    return -1;
  endfunction

  // Cell k of word idx is current in cell period 2 + 16*idx + k.
  function automatic logic [15:0] cellsWord(input int idx);
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < rise_q.size(); i++) begin
      int k;
      k = rise_q[i] / 16 - 2 - 16 * idx;
      if (k >= 0 && k < 16) w[15-k] = 1'b1;
    end
    return w;
  endfunction

  int acc1, acc2, acc3, n;
  int exp_rise[7] = '{56, 107, 136, 168, 197, 251, 277};

  initial begin
    RESET = 1'b1;
    WR_DATA = 8'h00;
    WR_MARK = 1'b0;
    WR_LAST = 1'b0;
    WR_VALID = 1'b0;
    PRECOMP = 4'd0;
    repeat (3) @(negedge MASTER_CLK);
    checkOutput("reset_ready", {31'd0, WR_READY}, 32'd1);
    checkOutput("reset_wrdata", {31'd0, FD_WRDATA}, 32'd0);
    checkOutput("reset_gate", {31'd0, FD_WRGATE}, 32'd0);
    checkOutput("reset_busy", {31'd0, BUSY}, 32'd0);
    checkOutput("reset_underrun", {31'd0, UNDERRUN}, 32'd0);
    RESET = 1'b0;
    @(negedge MASTER_CLK);

    $display("[TB] single 0x00 with last");
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, acc1);
    checkOutput("t1_busy", {31'd0, BUSY}, 32'd1);
    checkOutput("t1_gate", {31'd0, FD_WRGATE}, 32'd1);
    waitIdle("t1");
    checkOutput("t1_count", rise_q.size(), 32'd8);
    checkOutput("t1_first_rise", riseAt(0), 32'd40);
    checkOutput("t1_last_rise", riseAt(7), 32'd264);
    checkOutput("t1_width", widthAt(0), 32'd4);
    checkOutput("t1_cells", {16'd0, cellsWord(0)}, 32'h0000AAAA);
    checkOutput("t1_gate_len", gate_dur, 32'd288);
    checkOutput("t1_underrun", {31'd0, UNDERRUN}, 32'd0);

    $display("[TB] A1 with and without mark");
    applyStimulus(8'hA1, 1'b1, 1'b1, 1'b0, acc1);
    waitIdle("t2a");
    checkOutput("t2_mark_cells", {16'd0, cellsWord(0)}, 32'h00004489);
    applyStimulus(8'hA1, 1'b0, 1'b1, 1'b0, acc1);
    waitIdle("t2b");
    checkOutput("t2_plain_cells", {16'd0, cellsWord(0)}, 32'h000044A9);

    $display("[TB] 0x83 with precomp 3");
    PRECOMP = 4'd3;
    applyStimulus(8'h83, 1'b0, 1'b1, 1'b0, acc1);
    waitIdle("t3");
    checkOutput("t3_cells", {16'd0, cellsWord(0)}, 32'h00004AA5);
    checkOutput("t3_count", rise_q.size(), 32'd7);
    for (int i = 0; i < 7; i++) checkOutput($sformatf("t3_rise%0d", i), riseAt(i), exp_rise[i]);

    $display("[TB] 0x83 with precomp 15 clamped to 7");
    PRECOMP = 4'd15;
    applyStimulus(8'h83, 1'b0, 1'b1, 1'b0, acc1);
    waitIdle("t3c");
    checkOutput("t3c_late", riseAt(1), 32'd111);
    checkOutput("t3c_early", riseAt(4), 32'd193);
    PRECOMP = 4'd0;

    $display("[TB] three bytes back to back");
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, acc1);
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b1, acc2);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, acc3);
    checkOutput("t4_second_accept", acc2 - acc1, 32'd1);
    checkOutput("t4_third_accept", acc3 - acc1, 32'd257);
    waitIdle("t4");
    checkOutput("t4_word0", {16'd0, cellsWord(0)}, 32'h0000AAAA);
    checkOutput("t4_word1", {16'd0, cellsWord(1)}, 32'h00005555);
    checkOutput("t4_word2", {16'd0, cellsWord(2)}, 32'h00002AAA);
    checkOutput("t4_count", rise_q.size(), 32'd23);
    checkOutput("t4_gate_len", gate_dur, 32'd800);

    $display("[TB] underrun");
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, acc1);
    waitIdle("t5");
    checkOutput("t5_underrun", {31'd0, UNDERRUN}, 32'd1);
    checkOutput("t5_gate_len", gate_dur, 32'd288);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, acc1);
    checkOutput("t5_underrun_clear", {31'd0, UNDERRUN}, 32'd0);
    waitIdle("t5b");

    $display("[TB] reset mid pulse");
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, acc1);
    n = 0;
    while (!FD_WRDATA && n < 200) begin
      @(negedge MASTER_CLK);
      n++;
    end
    checkOutput("t6_pulse_seen", {31'd0, FD_WRDATA}, 32'd1);
    RESET = 1'b1;
    @(negedge MASTER_CLK);
    checkOutput("t6_wrdata", {31'd0, FD_WRDATA}, 32'd0);
    checkOutput("t6_gate", {31'd0, FD_WRGATE}, 32'd0);
    checkOutput("t6_busy", {31'd0, BUSY}, 32'd0);
    checkOutput("t6_ready", {31'd0, WR_READY}, 32'd1);
    RESET = 1'b0;
    repeat (2) @(negedge MASTER_CLK);

    $display("[TB] clock enable at half rate");
    clken_half = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, acc1);
    waitIdle("t7");
    checkOutput("t7_count", rise_q.size(), 32'd8);
    checkOutput("t7_spacing", riseAt(1) - riseAt(0), 32'd64);
    checkOutput("t7_span", riseAt(7) - riseAt(0), 32'd448);
    checkOutput("t7_width", widthAt(0), 32'd8);
    clken_half = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
